pi_loop_filter_gs: RTL and testbench

Synthesisable, parametrised PI loop filter with automatic gear-shifting between acquisition and tracking bandwidths. It sits between the Gardner timing-error detector and the NCO/phase accumulator in the symbol-timing loop. It adds the following, each described below:
- symmetric dead-zone truncation
- integrator and output saturation
- freeze and clear controls
- a lock detector that selects the gain set

---
 rtl/pi_loop_filter_gs_pkg.sv | 26 ++
 rtl/pi_loop_filter_gs_lock_detect.sv | 63 ++++++
 rtl/pi_loop_filter_gs.sv | 113 +++++++++++
 tb/tb_pi_loop_filter_gs.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_loop_filter_gs_pkg.sv
// Shared types and arithmetic helpers for the PI loop filter.
// Helpers work on a wide signed type so callers never overflow intermediates.
package loop_filter_pkg;

  typedef enum logic {LF_ACQ = 1'b0, LF_TRK = 1'b1} lf_state_t;

  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Symmetric clamp to +/-(2^(width-1)-1).
  function automatic calc_t sat_signed(input calc_t value, input int unsigned width);
    calc_t lim;
    lim = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
    if (value > lim)  return lim;
    if (value < -lim) return -lim;
    return value;
  endfunction

  // Divide by 2^k truncating toward zero, giving a dead zone symmetric about 0.
  function automatic calc_t shift_tz(input calc_t value, input int unsigned k);
    calc_t bias;
    bias = (value < 0) ? ((calc_t'(1) <<< k) - calc_t'(1)) : '0;
    return (value + bias) >>> k;
  endfunction

endpackage

// File: rtl/pi_loop_filter_gs_lock_detect.sv
// Lock detector: consecutive-sample counter plus ACQ/TRK state machine.
// Fed from the stage-1 registers, so state changes at the end of cycle N+1.
module lf_lock_detect
  import loop_filter_pkg::*;
#(
  parameter int WERR       = 18,
  parameter int LOCK_THR   = 256,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_e_valid,
  input  logic [WERR-1:0] i_e_abs,
  input  logic            i_clear,
  output lf_state_t       o_state,
  output logic            o_locked
);

  localparam int CW = $clog2((LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT) + 1);
  localparam logic [WERR:0] THR = (WERR+1)'(LOCK_THR);

  lf_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_locked;
  logic          w_qual;
  logic [CW-1:0] w_cnt_inc;

  assign w_qual    = ({1'b0, i_e_abs} <= THR);
  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_state  <= LF_ACQ;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (i_e_valid) begin
      case (r_state)
        LF_ACQ: begin
          if (!w_qual) r_cnt <= '0;
          else if (w_cnt_inc == CW'(LOCK_CNT)) begin
            r_state  <= LF_TRK;
            r_cnt    <= '0;
            r_locked <= 1'b1;
          end else r_cnt <= w_cnt_inc;
        end
        LF_TRK: begin
          if (w_qual) r_cnt <= '0;
          else if (w_cnt_inc == CW'(UNLOCK_CNT)) begin
            r_state  <= LF_ACQ;
            r_cnt    <= '0;
            r_locked <= 1'b0;
          end else r_cnt <= w_cnt_inc;
        end
        default: r_state <= LF_ACQ;
      endcase
    end
  end

  assign o_state  = r_state;
  assign o_locked = r_locked;

endmodule

// File: rtl/pi_loop_filter_gs.sv
// Two-stage PI loop filter with dead-zone scaling, saturation and lock-driven
// gear shifting. Define PI_LF_GEARSHIFT_EN to switch ACQ/TRK gains; otherwise TRK gains are fixed.
module pi_loop_filter_gs
  import loop_filter_pkg::*;
#(
  parameter int          WERR         = 18,
  parameter int          ACC_WIDTH    = 24,
  parameter int unsigned KP_SHIFT_ACQ = 5,
  parameter int unsigned KI_SHIFT_ACQ = 9,
  parameter int unsigned KP_SHIFT_TRK = 7,
  parameter int unsigned KI_SHIFT_TRK = 11,
  parameter int          LOCK_THR     = 256,
  parameter int          LOCK_CNT     = 64,
  parameter int          UNLOCK_CNT   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic signed [WERR-1:0] e_in_i,
  input  logic                   e_valid_i,
  input  logic                   freeze_i,
  input  logic                   clear_i,
  output logic signed [WERR-1:0] ctrl_o,
  output logic                   ctrl_val_o,
  output logic                   locked_o,
  output logic                   sat_o
);

`ifdef PI_LF_GEARSHIFT_EN
  localparam bit FIXED_TRK = 1'b0;
`else
  localparam bit FIXED_TRK = 1'b1;
`endif

  localparam calc_t ACC_MAX = (calc_t'(1) <<< (ACC_WIDTH - 1)) - calc_t'(1);

  lf_state_t                    w_state;
  logic                         w_use_trk;
  int unsigned                  w_kp, w_ki;
  calc_t                        w_e;
  logic                         r_s1_vld;
  logic signed [WERR-1:0]       r_prop, r_inc;
  logic [WERR-1:0]              r_abs;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [WERR-1:0]       r_ctrl;
  logic                         r_val, r_sat;
  calc_t                        w_acc_upd, w_out_sum, w_out_sat;
  logic                         w_acc_rail;

  assign w_use_trk = FIXED_TRK || (w_state == LF_TRK);
  assign w_kp      = w_use_trk ? KP_SHIFT_TRK : KP_SHIFT_ACQ;
  assign w_ki      = w_use_trk ? KI_SHIFT_TRK : KI_SHIFT_ACQ;
  assign w_e       = calc_t'(e_in_i);

  // Stage 1: scale with the gain set in force during the strobe cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      r_s1_vld <= 1'b0;
      r_prop   <= '0;
      r_inc    <= '0;
      r_abs    <= '0;
    end else begin
      r_s1_vld <= e_valid_i;
      if (e_valid_i) begin
        r_prop <= WERR'(shift_tz(w_e, w_kp));
        r_inc  <= WERR'(shift_tz(w_e, w_ki));
        r_abs  <= w_e[CALC_W-1] ? WERR'(-w_e) : WERR'(w_e);
      end
    end
  end

  lf_lock_detect #(
    .WERR      (WERR),
    .LOCK_THR  (LOCK_THR),
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT)
  ) u_lock (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_e_valid(r_s1_vld),
    .i_e_abs  (r_abs),
    .i_clear  (clear_i),
    .o_state  (w_state),
    .o_locked (locked_o)
  );

  // Stage 2: the output uses the updated (or frozen) integrator value.
  assign w_acc_upd  = freeze_i ? calc_t'(r_acc)
                               : sat_signed(calc_t'(r_acc) + calc_t'(r_inc), ACC_WIDTH);
  assign w_out_sum  = calc_t'(r_prop) + w_acc_upd;
  assign w_out_sat  = sat_signed(w_out_sum, WERR);
  assign w_acc_rail = (w_acc_upd == ACC_MAX) || (w_acc_upd == -ACC_MAX);

  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      r_acc  <= '0;
      r_ctrl <= '0;
      r_val  <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_val <= r_s1_vld;
      if (r_s1_vld) begin
        r_acc  <= ACC_WIDTH'(w_acc_upd);
        r_ctrl <= WERR'(w_out_sat);
        r_sat  <= w_acc_rail || (w_out_sat != w_out_sum);
      end
    end
  end

  assign ctrl_o     = r_ctrl;
  assign ctrl_val_o = r_val;
  assign sat_o      = r_sat;

endmodule

// File: tb/tb_pi_loop_filter_gs.sv
// Self-checking bench: stimulus timeline is built up front, a sample-level
// reference model derives the expected per-cycle outputs, then the DUT is driven.
module tb_pi_loop_filter_gs;

`ifdef PI_LF_GEARSHIFT_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif
  localparam int     NC   = 45000;
  localparam longint AMAX = 64'd8388607;
  localparam longint OMAX = 64'd131071;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [17:0] e_in_i = '0;
  logic               e_valid_i = 1'b0, freeze_i = 1'b0, clear_i = 1'b0;
  logic signed [17:0] ctrl_o;
  logic               ctrl_val_o, locked_o, sat_o;

  pi_loop_filter_gs dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .e_in_i    (e_in_i),
    .e_valid_i (e_valid_i),
    .freeze_i  (freeze_i),
    .clear_i   (clear_i),
    .ctrl_o    (ctrl_o),
    .ctrl_val_o(ctrl_val_o),
    .locked_o  (locked_o),
    .sat_o     (sat_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Stimulus timeline
  int  s_e[NC];
  bit  s_v[NC], s_fz[NC], s_clr[NC];
  int  np = 0;
  bit  cur_fz = 1'b0;

  // Expected and observed per-cycle values
  int     x_ctrl[NC];
  bit     x_val[NC], x_lock[NC], x_sat[NC], c_out[NC], c_lock[NC];
  longint x_acc[NC];
  int     o_ctrl[NC];
  bit     o_val[NC], o_lock[NC], o_sat[NC];
  longint o_acc[NC];

  task automatic put(input int e, input bit v, input bit clr);
    s_e[np] = e; s_v[np] = v; s_fz[np] = cur_fz; s_clr[np] = clr; np++;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) put(0, 1'b0, 1'b0);
  endtask
  task automatic strobe(input int e, input int n);
    for (int k = 0; k < n; k++) put(e, 1'b1, 1'b0);
  endtask

  function automatic longint tz(input longint e, input int k);
    return e / (longint'(1) << k);
  endfunction
  function automatic longint clampv(input longint v, input longint m);
    return (v > m) ? m : ((v < -m) ? -m : v);
  endfunction

  task automatic set_out(input int c, input longint ctrl, input bit sat, input longint acc);
    c_out[c] = 1'b1; x_ctrl[c] = int'(ctrl); x_sat[c] = sat; x_acc[c] = acc;
  endtask

  // Sample-level model: gains follow the lock state that is in force when the
  // sample is strobed; a lock change takes effect two cycles after its sample.
  task automatic build_model();
    int st, st_prev, st_time, cnt, g;
    longint acc, p, i, sum, out, e;
    bit q;
    st = 0; st_prev = 0; st_time = 0; cnt = 0; acc = 0;
    for (int t = 0; t < np; t++) begin
      if (s_clr[t]) begin
        acc = 0; st = 0; st_prev = 0; st_time = 0; cnt = 0;
        set_out(t + 1, 0, 1'b0, 0);
        c_lock[t+1] = 1'b1; x_lock[t+1] = 1'b0;
      end
      if (s_v[t] && !s_clr[t] && !s_clr[t+1]) begin
        e = longint'(s_e[t]);
        g = GS ? ((t >= st_time) ? st : st_prev) : 1;
        p = tz(e, g ? 7 : 5);
        i = tz(e, g ? 11 : 9);
        if (!s_fz[t+1]) acc = clampv(acc + i, AMAX);
        sum = p + acc;
        out = clampv(sum, OMAX);
        x_val[t+2] = 1'b1;
        set_out(t + 2, out, (acc == AMAX) || (acc == -AMAX) || (out != sum), acc);
        q = ((e < 0) ? -e : e) <= 256;
        if (st == 0) begin
          if (!q) cnt = 0;
          else begin
            cnt++;
            if (cnt == 64) begin
              st_prev = 0; st = 1; st_time = t + 2; cnt = 0;
              c_lock[t+2] = 1'b1; x_lock[t+2] = 1'b1;
            end
          end
        end else begin
          if (q) cnt = 0;
          else begin
            cnt++;
            if (cnt == 16) begin
              st_prev = 1; st = 0; st_time = t + 2; cnt = 0;
              c_lock[t+2] = 1'b1; x_lock[t+2] = 1'b0;
            end
          end
        end
      end
    end
    for (int c = 1; c < np + 3; c++) begin
      if (!c_out[c]) begin
        x_ctrl[c] = x_ctrl[c-1]; x_sat[c] = x_sat[c-1]; x_acc[c] = x_acc[c-1];
      end
      if (!c_lock[c]) x_lock[c] = x_lock[c-1];
    end
  endtask

  int t_s1, t_s2, t_l300, t_l64, t_l0, t_u16, t_f, t_c, t_c2, t_p, t_n, nt;
  int t_dz[4];
  int dz_e[4] = '{-31, -32, 511, -512};
  int dz_x[4];
  int re;
  bit rv;

  initial begin
    dz_x[0] = 0;
    dz_x[1] = GS ? -1 : 0;
    dz_x[2] = GS ? 15 : 3;
    dz_x[3] = GS ? -17 : -4;

    // Directed scenarios
    idle(3);
    put(0, 1'b0, 1'b1); idle(2);
    t_s1 = np; strobe(4096, 1); idle(3);
    t_s2 = np; strobe(4096, 1); idle(3);
    for (int k = 0; k < 4; k++) begin
      put(0, 1'b0, 1'b1); idle(2);
      t_dz[k] = np; strobe(dz_e[k], 1); idle(3);
    end
    put(0, 1'b0, 1'b1); idle(2);
    strobe(100, 63); t_l300 = np; strobe(300, 1); idle(3);
    t_l64 = np + 63; strobe(100, 64); idle(3);
    strobe(1000, 15); t_l0 = np; strobe(0, 1); idle(3);
    t_u16 = np + 15; strobe(1000, 16); idle(3);
    put(0, 1'b0, 1'b1); idle(2); strobe(4096, 3); idle(3);
    cur_fz = 1'b1; idle(1); t_f = np; strobe(4096, 4); idle(3); cur_fz = 1'b0; idle(2);
    put(0, 1'b0, 1'b1); idle(2); strobe(100, 64); idle(2); strobe(4096, 1); idle(3);
    t_c = np; strobe(4096, 1); put(4096, 1'b1, 1'b1); idle(3);
    t_c2 = np; strobe(4096, 1); idle(3);
    put(0, 1'b0, 1'b1); idle(2);
    strobe(131071, 34000); t_p = np - 1;
    t_n = np; strobe(-131072, 2000); idle(3);
    // Randomised: alternating small-error (locking) and mixed segments
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 500; k++) begin
        rv = ($urandom_range(9) < 7);
        if (s % 2 == 0) re = int'($urandom_range(400)) - 200;
        else if ($urandom_range(1) == 1) re = int'($urandom_range(262143)) - 131072;
        else re = int'($urandom_range(800)) - 400;
        cur_fz = ($urandom_range(4) == 0);
        put(re, rv, ($urandom_range(199) == 0));
      end
    end
    cur_fz = 1'b0; idle(3);
    build_model();
    nt = np + 3;

    // Reset
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_ctrl", 64'(ctrl_o), 0);
      chk("rst_val",  64'(ctrl_val_o), 0);
      chk("rst_lock", 64'(locked_o), 0);
      chk("rst_sat",  64'(sat_o), 0);
    end
    reset_n = 1'b1;

    for (int c = 0; c < nt; c++) begin
      @(posedge clk); #1;
      o_ctrl[c] = int'(ctrl_o); o_val[c] = ctrl_val_o; o_lock[c] = locked_o;
      o_sat[c] = sat_o; o_acc[c] = longint'(dut.r_acc);
      chk("ctrl", 64'(ctrl_o),     64'(x_ctrl[c]));
      chk("val",  64'(ctrl_val_o), 64'(x_val[c]));
      chk("lock", 64'(locked_o),   64'(x_lock[c]));
      chk("sat",  64'(sat_o),      64'(x_sat[c]));
      chk("acc",  64'(dut.r_acc),  x_acc[c]);
      if (c < np) begin
        e_in_i = 18'(s_e[c]); e_valid_i = s_v[c]; freeze_i = s_fz[c]; clear_i = s_clr[c];
      end else begin
        e_in_i = '0; e_valid_i = 1'b0; freeze_i = 1'b0; clear_i = 1'b0;
      end
      if (n_fail > 50) break;
    end

    // Spot checks against hand-derived constants
    chk("single1",     64'(o_ctrl[t_s1+2]), GS ? 136 : 34);
    chk("single1_val", 64'(o_val[t_s1+2]), 1);
    chk("single1_one", 64'(o_val[t_s1+3]), 0);
    chk("single2",     64'(o_ctrl[t_s2+2]), GS ? 144 : 36);
    for (int k = 0; k < 4; k++) chk("deadzone", 64'(o_ctrl[t_dz[k]+2]), 64'(dz_x[k]));
    chk("lock_300",    64'(o_lock[t_l300+2]), 0);
    chk("lock_pre",    64'(o_lock[t_l64+1]), 0);
    chk("lock_rise",   64'(o_lock[t_l64+2]), 1);
    chk("lock_hold",   64'(o_lock[t_l0+2]), 1);
    chk("unlock_pre",  64'(o_lock[t_u16+1]), 1);
    chk("unlock_fall", 64'(o_lock[t_u16+2]), 0);
    chk("freeze_out1", 64'(o_ctrl[t_f+2]), GS ? 152 : 38);
    chk("freeze_out4", 64'(o_ctrl[t_f+5]), GS ? 152 : 38);
    chk("freeze_acc",  o_acc[t_f+5], GS ? 24 : 6);
    chk("clr_locked",  64'(o_lock[t_c+1]), 1);
    chk("clr_nz",      64'(o_ctrl[t_c+1] != 0), 1);
    chk("clr_ctrl",    64'(o_ctrl[t_c+2]), 0);
    chk("clr_lock",    64'(o_lock[t_c+2]), 0);
    chk("clr_val0",    64'(o_val[t_c+2]), 0);
    chk("clr_val1",    64'(o_val[t_c+3]), 0);
    chk("clr_acq",     64'(o_ctrl[t_c2+2]), GS ? 136 : 34);
    chk("sat_ctrl",    64'(o_ctrl[t_p+2]), 131071);
    chk("sat_flag",    64'(o_sat[t_p+2]), 1);
`ifdef PI_LF_GEARSHIFT_EN
    chk("sat_rail",    o_acc[t_p+2], 8388607);
`endif
    for (int k = 1; k < 4; k++)
      chk("acc_dec", 64'(o_acc[t_n+2+k*500] < o_acc[t_n+2+(k-1)*500]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
